// File: rtl/delay_initiator_pkg.sv
// Shared encoding for the trigger/time_out delay handshake.
// The responder uses the same state values.
package delay_initiator_pkg;
  localparam int DEFAULT_WIDTH = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    RELEASE = 2'b10
  } state_e;
endpackage

// File: rtl/delay_initiator_if.sv
// Caller/responder-facing signals of the delay initiator.
// The master modport is the initiator side.
interface delay_initiator_if
  import delay_initiator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             time_out;
  logic             trigger;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             done;
  logic             error;

  modport master (
    input  start, time_out,
    output trigger, busy, count, done, error
  );

  modport slave (
    output start, time_out,
    input  trigger, busy, count, done, error
  );
endinterface

// File: rtl/delay_initiator.sv
// Raises trigger, measures cycles until time_out, waits for release and
// strobes done with the latency; a shared counter doubles as the watchdog.
module delay_initiator
  import delay_initiator_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_WAIT = 16383
) (
  input logic               clk,
  input logic               rst,
  delay_initiator_if.master bus
);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             trig_q, trig_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // The watchdog compare is checked before the increment, so cnt never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    trig_d  = trig_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        trig_d = 1'b0;
        if (bus.start) begin
          state_d = ARM;
          trig_d  = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ARM: begin
        if (bus.time_out) begin
          count_d = cnt_q;
          trig_d  = 1'b0;
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q == MAX_CNT) begin
          err_d   = 1'b1;
          trig_d  = 1'b0;
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        trig_d = 1'b0;
        if (!bus.time_out) begin
          state_d = IDLE;
          done_d  = !err_q;
        end else if (cnt_q == MAX_CNT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        trig_d  = 1'b0;
      end
    endcase
  end

  assign bus.trigger = trig_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.error   = err_q;
endmodule

// File: tb/tb_delay_initiator.sv
// Directed bench: behavioural delay responder plus a scoreboard of expected
// latencies popped on every done strobe.
module tb_delay_initiator;
  localparam int WIDTH    = 14;
  localparam int MAX_WAIT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_initiator_if #(.WIDTH(WIDTH)) bus ();

  delay_initiator #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Responder: time_out rises N+1 cycles after trigger, falls once trigger drops.
  int               mode   = 0;  // 0 responder, 1 tied low, 2 tied high
  logic [WIDTH-1:0] resp_n = '0;
  logic [WIDTH-1:0] r_cnt  = '0;
  logic             r_to   = 1'b0;

  always @(posedge clk) begin
    if (!bus.trigger) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else if (r_cnt == resp_n) begin
      r_to <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.time_out = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : r_to;

  int unsigned exp_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pop();
    int unsigned e;
    chk("done_expected", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count", 32'(bus.count), e);
    end
    chk("done_idle", 32'(bus.busy), 0);
    chk("done_no_error", 32'(bus.error), 0);
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (bus.done) begin
        got = 1'b1;
        check_pop();
      end
    end
    chk("done_seen", 32'(got), 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int ndone;
    int idx;
    bit prev_done;
    bus.start = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_trigger", 32'(bus.trigger), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_error", 32'(bus.error), 0);
    rst = 1'b0;
    tick();

    // Single measurement, N=5
    mode = 0; resp_n = 5;
    exp_q.push_back(6);
    pulse_start();
    chk("trig_rise", 32'(bus.trigger), 1);
    chk("busy_rise", 32'(bus.busy), 1);
    wait_done(50);
    tick();

    // Back-to-back with start held, N=1
    resp_n = 1;
    bus.start = 1'b1;
    exp_q.push_back(2);
    ndone = 0; prev_done = 1'b0;
    for (int i = 0; i < 40 && ndone < 4; i++) begin
      tick();
      if (prev_done) chk("b2b_trig_rise", 32'(bus.trigger), 1);
      prev_done = bus.done;
      if (bus.done) begin
        ndone++;
        check_pop();
        if (ndone < 4) exp_q.push_back(2);
        else bus.start = 1'b0;
      end
    end
    chk("b2b_dones", 32'(ndone), 4);
    tick();
    chk("b2b_stop_trig", 32'(bus.trigger), 0);
    chk("b2b_stop_busy", 32'(bus.busy), 0);

    // ARM watchdog: time_out tied low
    mode = 1;
    pulse_start();
    idx = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("arm_wd_no_done", 32'(bus.done), 0);
      if (bus.error) begin
        idx = i;
        break;
      end
    end
    chk("arm_wd_cycle", 32'(idx), 11);
    chk("arm_wd_trig", 32'(bus.trigger), 0);
    tick();
    chk("arm_wd_idle", 32'(bus.busy), 0);
    chk("arm_wd_done", 32'(bus.done), 0);
    chk("arm_wd_sticky", 32'(bus.error), 1);
    chk("arm_wd_count_kept", 32'(bus.count), 2);
    mode = 0; resp_n = 3;
    exp_q.push_back(4);
    pulse_start();
    chk("err_cleared", 32'(bus.error), 0);
    wait_done(50);
    tick();

    // time_out stuck high: count 0, then RELEASE watchdog
    mode = 2;
    pulse_start();
    tick();
    chk("stuck_count0", 32'(bus.count), 0);
    chk("stuck_trig", 32'(bus.trigger), 0);
    chk("stuck_busy", 32'(bus.busy), 1);
    idx = 0;
    for (int i = 2; i <= 30; i++) begin
      tick();
      chk("stuck_no_done", 32'(bus.done), 0);
      if (!bus.busy) begin
        idx = i;
        break;
      end
    end
    chk("rel_wd_cycle", 32'(idx), 12);
    chk("rel_wd_error", 32'(bus.error), 1);
    chk("rel_wd_count", 32'(bus.count), 0);
    mode = 0;
    tick();

    // Asynchronous reset three cycles into ARM
    resp_n = 5;
    pulse_start();
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("arst_trigger", 32'(bus.trigger), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_error", 32'(bus.error), 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick(); tick();
    exp_q.push_back(6);
    pulse_start();
    wait_done(50);

    // start pulsed while busy is ignored
    tick();
    resp_n = 4;
    exp_q.push_back(5);
    pulse_start();
    tick(); tick();
    pulse_start();
    wait_done(50);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("busy_start_extra_done", 32'(ndone), 0);
    chk("busy_start_idle", 32'(bus.busy), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
